// File: rtl/fifo_pkg.sv
// Shared constants for the register-file FIFO.
//   FIFO_N     : default data word width in bits
//   FIFO_DEPTH : default number of entries (power of two, >= 2)
// The occupancy type depends on the instance depth, so each module derives
// its own count_t from AW locally.
package fifo_pkg;

    localparam int FIFO_N     = 32;
    localparam int FIFO_DEPTH = 8;

endpackage : fifo_pkg

// File: rtl/fifo_registros_if.sv
// Producer/consumer bus of the register-file FIFO.
//   push_i/data_i : write request and write word (from master)
//   pop_i         : read request (from master)
//   data_o        : registered read word, holds between pops
//   valid_o       : one-cycle strobe when data_o carries a freshly popped word
//   full_o/empty_o/count_o : occupancy status
//   overflow_o/underflow_o : sticky error flags, cleared only by reset
// Handshake: a push is taken on the rising edge where push_i=1 and the FIFO
// is not full (or a pop is taken on the same edge); a pop is taken where
// pop_i=1 and the FIFO is not empty, and its word appears on data_o with
// valid_o=1 one cycle later. Requests that are not taken are dropped, not
// held, and set the matching sticky flag.
interface fifo_registros_if
    import fifo_pkg::*;
#(
    parameter int N     = FIFO_N,
    parameter int DEPTH = FIFO_DEPTH
);
    localparam int AW = $clog2(DEPTH);

    logic          push_i;
    logic [N-1:0]  data_i;
    logic          pop_i;
    logic [N-1:0]  data_o;
    logic          valid_o;
    logic          full_o;
    logic          empty_o;
    logic [AW:0]   count_o;
    logic          overflow_o;
    logic          underflow_o;

    modport master (
        output push_i, data_i, pop_i,
        input  data_o, valid_o, full_o, empty_o, count_o, overflow_o, underflow_o
    );

    modport slave (
        input  push_i, data_i, pop_i,
        output data_o, valid_o, full_o, empty_o, count_o, overflow_o, underflow_o
    );

endinterface : fifo_registros_if

// File: rtl/fifo_ptr.sv
// AW-bit wrap-around pointer used for both the write and read side.
//   clk_i : clock, rst_i : synchronous active-high reset (pointer -> 0)
//   inc_i : advance by one this edge (wraps DEPTH-1 -> 0 naturally, since
//           DEPTH is a power of two)
//   ptr_o : current pointer value
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int AW = $clog2(FIFO_DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          inc_i,
    output logic [AW-1:0] ptr_o
);

    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) begin
            ptr_d = ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule : fifo_ptr

// File: rtl/fifo_registros.sv
// DEPTH-entry circular buffer of N-bit words with a registered read port.
//   clk_i : clock (rising edge)
//   rst_i : synchronous active-high reset; clears pointers, count, output
//           register and sticky flags, and ignores any push/pop that cycle
//   bus   : fifo_registros_if slave port (push/pop requests, read data,
//           valid strobe, occupancy and sticky error flags)
module fifo_registros
    import fifo_pkg::*;
#(
    parameter int N     = FIFO_N,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    fifo_registros_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    typedef logic [AW:0] count_t;

    logic [N-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    count_t        count_q,     count_d;
    logic [N-1:0]  data_q,      data_d;
    logic          valid_q,     valid_d;
    logic          overflow_q,  overflow_d;
    logic          underflow_q, underflow_d;

    logic full;
    logic empty;
    logic pop_ok;
    logic push_ok;

    assign full  = (count_q == count_t'(DEPTH));
    assign empty = (count_q == '0);

    // A pop frees a slot on the same edge, so a push at full is still taken
    // when a pop goes with it. At empty the pop is refused; there is no
    // write-through path from data_i to data_o.
    assign pop_ok  = bus.pop_i && !empty;
    assign push_ok = bus.push_i && (!full || pop_ok);

    fifo_ptr #(.AW(AW)) u_wr_ptr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (push_ok),
        .ptr_o (wr_ptr)
    );

    fifo_ptr #(.AW(AW)) u_rd_ptr (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (pop_ok),
        .ptr_o (rd_ptr)
    );

    always_comb begin
        count_d     = count_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (push_ok && !pop_ok) begin
            count_d = count_q + count_t'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - count_t'(1);
        end

        if (pop_ok) begin
            data_d  = mem_q[rd_ptr];
            valid_d = 1'b1;
        end

        if (bus.push_i && !push_ok) begin
            overflow_d = 1'b1;
        end
        if (bus.pop_i && empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage needs no reset; only the write itself is blocked during reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push_ok) begin
            mem_q[wr_ptr] <= bus.data_i;
        end
    end

    assign bus.data_o      = data_q;
    assign bus.valid_o     = valid_q;
    assign bus.count_o     = count_q;
    assign bus.full_o      = full;
    assign bus.empty_o     = empty;
    assign bus.overflow_o  = overflow_q;
    assign bus.underflow_o = underflow_q;

endmodule : fifo_registros

// File: tb/tb_fifo_registros.sv
module tb_fifo_registros;

  localparam int N     = 32;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_registros_if #(.N(N), .DEPTH(DEPTH)) bus ();

  fifo_registros #(.N(N), .DEPTH(DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- behavioural model ----------------
  // Queue of stored words plus the expected registered outputs.
  logic [N-1:0] exp_q[$];
  logic [N-1:0] m_data;
  logic         m_valid;
  logic         m_ovf;
  logic         m_udf;
  bit           model_live = 1'b0;

  always @(posedge clk) begin
    bit was_empty;
    bit pop_take;
    bit push_take;
    if (rst) begin
      exp_q.delete();
      m_data     = '0;
      m_valid    = 1'b0;
      m_ovf      = 1'b0;
      m_udf      = 1'b0;
      model_live = 1'b1;
    end else begin
      was_empty = (exp_q.size() == 0);
      pop_take  = bus.pop_i && !was_empty;
      push_take = bus.push_i && ((exp_q.size() < DEPTH) || pop_take);
      m_valid = 1'b0;
      if (pop_take) begin
        m_data  = exp_q.pop_front();
        m_valid = 1'b1;
      end
      if (bus.push_i && !push_take) m_ovf = 1'b1;
      if (bus.pop_i && was_empty)   m_udf = 1'b1;
      if (push_take) exp_q.push_back(bus.data_i);
    end
  end

  // ---------------- scoreboard compare ----------------
  task automatic cmp(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_live) begin
      cmp("sb_data",  N'(bus.data_o), m_data);
      cmp("sb_valid", N'(bus.valid_o), N'(m_valid));
      cmp("sb_count", N'(bus.count_o), N'(exp_q.size()));
      cmp("sb_full",  N'(bus.full_o), N'(exp_q.size() == DEPTH));
      cmp("sb_empty", N'(bus.empty_o), N'(exp_q.size() == 0));
      cmp("sb_ovf",   N'(bus.overflow_o), N'(m_ovf));
      cmp("sb_udf",   N'(bus.underflow_o), N'(m_udf));
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic p, input logic [N-1:0] d, input logic po);
    bus.push_i = p;
    bus.data_i = d;
    bus.pop_i  = po;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0);
  endtask

  // ---------------- directed stimulus with literal checks ----------------
  initial begin
    bus.push_i = 1'b0;
    bus.data_i = '0;
    bus.pop_i  = 1'b0;

    // reset then idle
    rst = 1'b1;
    idle();
    idle();
    rst = 1'b0;
    repeat (3) idle();
    cmp("rst_empty", N'(bus.empty_o), 1);
    cmp("rst_count", N'(bus.count_o), 0);
    cmp("rst_data",  bus.data_o, 0);
    cmp("rst_valid", N'(bus.valid_o), 0);
    cmp("rst_ovf",   N'(bus.overflow_o), 0);
    cmp("rst_udf",   N'(bus.underflow_o), 0);

    // ordered fill and drain
    step(1'b1, 32'h11, 1'b0);
    step(1'b1, 32'h22, 1'b0);
    step(1'b1, 32'h33, 1'b0);
    cmp("fill3_count", N'(bus.count_o), 3);
    step(1'b0, '0, 1'b1);
    cmp("drain_d0", bus.data_o, 32'h11);
    cmp("drain_v0", N'(bus.valid_o), 1);
    step(1'b0, '0, 1'b1);
    cmp("drain_d1", bus.data_o, 32'h22);
    step(1'b0, '0, 1'b1);
    cmp("drain_d2", bus.data_o, 32'h33);
    cmp("drain_v2", N'(bus.valid_o), 1);
    idle();
    cmp("drain_empty", N'(bus.empty_o), 1);
    cmp("drain_count", N'(bus.count_o), 0);
    cmp("drain_hold",  bus.data_o, 32'h33);
    cmp("drain_vlow",  N'(bus.valid_o), 0);

    // full, overflow and wrap
    for (int i = 0; i < DEPTH; i++) step(1'b1, N'(i), 1'b0);
    cmp("full_flag",  N'(bus.full_o), 1);
    cmp("full_count", N'(bus.count_o), 8);
    step(1'b1, 32'hAA, 1'b0);
    cmp("ovf_set",    N'(bus.overflow_o), 1);
    cmp("ovf_count",  N'(bus.count_o), 8);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, '0, 1'b1);
      cmp("full_drain", bus.data_o, N'(i));
    end
    step(1'b1, 32'h08, 1'b0);
    step(1'b0, '0, 1'b1);
    cmp("wrap_data", bus.data_o, 32'h08);

    // simultaneous push+pop at full
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h40 + N'(i), 1'b0);
    step(1'b1, 32'hBB, 1'b1);
    cmp("pp_full_data",  bus.data_o, 32'h40);
    cmp("pp_full_count", N'(bus.count_o), 8);
    for (int i = 1; i < DEPTH; i++) begin
      step(1'b0, '0, 1'b1);
      cmp("pp_full_drain", bus.data_o, 32'h40 + N'(i));
    end
    step(1'b0, '0, 1'b1);
    cmp("pp_full_last", bus.data_o, 32'hBB);

    // simultaneous push+pop at empty
    step(1'b1, 32'hCC, 1'b1);
    cmp("pp_empty_valid", N'(bus.valid_o), 0);
    cmp("pp_empty_udf",   N'(bus.underflow_o), 1);
    cmp("pp_empty_count", N'(bus.count_o), 1);
    step(1'b0, '0, 1'b1);
    cmp("pp_empty_pop", bus.data_o, 32'hCC);

    // underflow while empty, sticky
    step(1'b0, '0, 1'b1);
    cmp("udf_valid", N'(bus.valid_o), 0);
    cmp("udf_hold",  bus.data_o, 32'hCC);
    cmp("udf_flag",  N'(bus.underflow_o), 1);
    repeat (2) idle();
    cmp("udf_sticky", N'(bus.underflow_o), 1);

    // reset mid-operation with push and pop presented
    for (int i = 0; i < 5; i++) step(1'b1, 32'h70 + N'(i), 1'b0);
    rst = 1'b1;
    step(1'b1, 32'hDD, 1'b1);
    rst = 1'b0;
    cmp("mrst_count", N'(bus.count_o), 0);
    cmp("mrst_empty", N'(bus.empty_o), 1);
    cmp("mrst_ovf",   N'(bus.overflow_o), 0);
    cmp("mrst_udf",   N'(bus.underflow_o), 0);
    cmp("mrst_data",  bus.data_o, 0);
    step(1'b0, '0, 1'b1);
    cmp("mrst_pop_udf",   N'(bus.underflow_o), 1);
    cmp("mrst_pop_valid", N'(bus.valid_o), 0);
    idle();

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_fifo_registros
